// File: rtl/l2_dr_arb_if.sv
// Directory-side channels of the L2 directory arbiter: two request sources, one merged
// request sink, one snack source and two steered snack sinks, all valid/retry.
interface l2_dr_arb_if #(
    parameter int unsigned REQ_W   = 128,
    parameter int unsigned SNACK_W = 600
);
    logic               l2_req_valid;
    logic               l2_req_retry;
    logic [REQ_W-1:0]   l2_req;
    logic               tlb_req_valid;
    logic               tlb_req_retry;
    logic [REQ_W-1:0]   tlb_req;
    logic               l2todr_req_valid;
    logic               l2todr_req_retry;
    logic [REQ_W-1:0]   l2todr_req;
    logic               drtol2_snack_valid;
    logic               drtol2_snack_retry;
    logic [SNACK_W-1:0] drtol2_snack;
    logic               l2_snack_valid;
    logic               l2_snack_retry;
    logic [SNACK_W-1:0] l2_snack;
    logic               tlb_snack_valid;
    logic               tlb_snack_retry;
    logic [SNACK_W-1:0] tlb_snack;

    // Arbiter view
    modport slave (
        input  l2_req_valid, l2_req, tlb_req_valid, tlb_req, l2todr_req_retry,
        input  drtol2_snack_valid, drtol2_snack, l2_snack_retry, tlb_snack_retry,
        output l2_req_retry, tlb_req_retry, l2todr_req_valid, l2todr_req,
        output drtol2_snack_retry, l2_snack_valid, l2_snack, tlb_snack_valid, tlb_snack
    );

    // Surrounding L2 / L2TLB / directory view
    modport master (
        output l2_req_valid, l2_req, tlb_req_valid, tlb_req, l2todr_req_retry,
        output drtol2_snack_valid, drtol2_snack, l2_snack_retry, tlb_snack_retry,
        input  l2_req_retry, tlb_req_retry, l2todr_req_valid, l2todr_req,
        input  drtol2_snack_retry, l2_snack_valid, l2_snack, tlb_snack_valid, tlb_snack
    );
endinterface

// File: rtl/l2_dr_arb.sv
// Round-robin merge of L2 and L2TLB directory requests into one buffered channel, and
// nodeid-parity steering of directory snacks into per-destination buffers.
module l2_dr_arb #(
    parameter int unsigned REQ_W         = 128,
    parameter int unsigned SNACK_W       = 600,
    parameter int unsigned SNACK_NID_BIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    l2_dr_arb_if.slave bus
);
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned NQ    = 2;

    logic [REQ_W-1:0] reqq_mem_q [DEPTH];
    logic             reqq_wr_q, reqq_wr_d;
    logic             reqq_rd_q, reqq_rd_d;
    logic [CNT_W-1:0] reqq_cnt_q, reqq_cnt_d;
    logic             rr_q, rr_d;
    logic             space;
    logic             grant_l2, grant_tlb;
    logic             req_enq, req_deq;
    logic [REQ_W-1:0] req_wdata;

    // Space depends only on the registered count, so retries never see the dequeue side
    always_comb begin
        space      = (reqq_cnt_q < CNT_W'(DEPTH));
        grant_l2   = space & bus.l2_req_valid  & ~(bus.tlb_req_valid & rr_q);
        grant_tlb  = space & bus.tlb_req_valid & ~(bus.l2_req_valid & ~rr_q);
        req_enq    = grant_l2 | grant_tlb;
        req_deq    = (reqq_cnt_q != '0) & ~bus.l2todr_req_retry;
        req_wdata  = grant_tlb ? bus.tlb_req : bus.l2_req;
        reqq_wr_d  = reqq_wr_q ^ req_enq;
        reqq_rd_d  = reqq_rd_q ^ req_deq;
        reqq_cnt_d = reqq_cnt_q + CNT_W'(req_enq) - CNT_W'(req_deq);
        // After any grant the pointer favours the source that was not served
        rr_d       = req_enq ? ~grant_tlb : rr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reqq_wr_q  <= 1'b0;
            reqq_rd_q  <= 1'b0;
            reqq_cnt_q <= '0;
            rr_q       <= 1'b0;
        end else begin
            reqq_wr_q  <= reqq_wr_d;
            reqq_rd_q  <= reqq_rd_d;
            reqq_cnt_q <= reqq_cnt_d;
            rr_q       <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_enq) reqq_mem_q[reqq_wr_q] <= req_wdata;
    end

    assign bus.l2todr_req_valid = (reqq_cnt_q != '0);
    assign bus.l2todr_req       = reqq_mem_q[reqq_rd_q];
    // The loser's retry follows the competitor's valid; everything else is registered
    assign bus.l2_req_retry     = reset & (~space | (bus.tlb_req_valid & rr_q));
    assign bus.tlb_req_retry    = reset & (~space | (bus.l2_req_valid & ~rr_q));

    // Snack queues: index 0 feeds the L2, index 1 feeds the L2TLB
    logic [SNACK_W-1:0] sq_mem_q [NQ][DEPTH];
    logic [NQ-1:0]      sq_wr_q, sq_wr_d;
    logic [NQ-1:0]      sq_rd_q, sq_rd_d;
    logic [CNT_W-1:0]   sq_cnt_q [NQ];
    logic [CNT_W-1:0]   sq_cnt_d [NQ];
    logic [NQ-1:0]      sq_enq, sq_deq, sq_sink_retry;
    logic               snack_full, snack_xfer, snack_odd;

    always_comb begin
        snack_full    = (sq_cnt_q[0] == CNT_W'(DEPTH)) | (sq_cnt_q[1] == CNT_W'(DEPTH));
        snack_xfer    = bus.drtol2_snack_valid & ~snack_full;
        snack_odd     = bus.drtol2_snack[SNACK_NID_BIT];
        sq_sink_retry = {bus.tlb_snack_retry, bus.l2_snack_retry};
        sq_enq        = {snack_xfer & snack_odd, snack_xfer & ~snack_odd};
        sq_deq        = '0;
        sq_wr_d       = sq_wr_q;
        sq_rd_d       = sq_rd_q;
        sq_cnt_d      = sq_cnt_q;
        for (int q = 0; q < NQ; q++) begin
            sq_deq[q]   = (sq_cnt_q[q] != '0) & ~sq_sink_retry[q];
            sq_wr_d[q]  = sq_wr_q[q] ^ sq_enq[q];
            sq_rd_d[q]  = sq_rd_q[q] ^ sq_deq[q];
            sq_cnt_d[q] = sq_cnt_q[q] + CNT_W'(sq_enq[q]) - CNT_W'(sq_deq[q]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_wr_q  <= '0;
            sq_rd_q  <= '0;
            sq_cnt_q <= '{default: '0};
        end else begin
            sq_wr_q  <= sq_wr_d;
            sq_rd_q  <= sq_rd_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (sq_enq[q]) sq_mem_q[q][sq_wr_q[q]] <= bus.drtol2_snack;
        end
    end

    assign bus.drtol2_snack_retry = snack_full;
    assign bus.l2_snack_valid     = (sq_cnt_q[0] != '0);
    assign bus.l2_snack           = sq_mem_q[0][sq_rd_q[0]];
    assign bus.tlb_snack_valid    = (sq_cnt_q[1] != '0);
    assign bus.tlb_snack          = sq_mem_q[1][sq_rd_q[1]];
endmodule

// File: tb/tb_l2_dr_arb.sv
// Self-checking bench for l2_dr_arb: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_l2_dr_arb;
    localparam int unsigned REQ_W         = 128;
    localparam int unsigned SNACK_W       = 600;
    localparam int unsigned REQ_NID_BIT   = 0;
    localparam int unsigned SNACK_NID_BIT = 0;
    localparam logic [REQ_W-1:0] PL = REQ_W'(32'h1234_00A0);
    localparam logic [REQ_W-1:0] PT = REQ_W'(32'h5678_00B1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    l2_dr_arb_if #(.REQ_W(REQ_W), .SNACK_W(SNACK_W)) bus ();

    l2_dr_arb #(
        .REQ_W(REQ_W), .SNACK_W(SNACK_W), .SNACK_NID_BIT(SNACK_NID_BIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic l2v, tlbv, dret;
        logic e_l2r, e_tlbr, e_ov;
        int   e_src;
    } vec_t;

    vec_t vec [12];

    logic [REQ_W-1:0]   mreq [$];
    logic [SNACK_W-1:0] ms_l2 [$];
    logic [SNACK_W-1:0] ms_tlb [$];
    bit                 mrr, l2_pend, tlb_pend, sn_pend;
    bit                 dret_r, l2sr_r, tlbsr_r, e_space, e_ov, e_sfull;
    int                 win;
    logic [REQ_W-1:0]   l2_pay, tlb_pay;
    logic [SNACK_W-1:0] sn_pay;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkr(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chks(input string name, input logic [SNACK_W-1:0] act, input logic [SNACK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SNACK_W-1:0] mk_snack(input int unsigned n);
        logic [SNACK_W-1:0] v;
        v = SNACK_W'(32'hC0DE_0000 | n);
        v[SNACK_NID_BIT] = n[0];
        return v;
    endfunction

    function automatic logic [SNACK_W-1:0] rand_snack();
        logic [SNACK_W-1:0] v = '0;
        for (int i = 0; i < 19; i++) v = (v << 32) | SNACK_W'($urandom);
        return v;
    endfunction

    function automatic logic [REQ_W-1:0] rand_req(input bit odd);
        logic [REQ_W-1:0] v = '0;
        for (int i = 0; i < 4; i++) v = (v << 32) | REQ_W'($urandom);
        v[REQ_NID_BIT] = odd;
        return v;
    endfunction

    task automatic drive_idle();
        bus.l2_req_valid       = 1'b0;
        bus.l2_req             = '0;
        bus.tlb_req_valid      = 1'b0;
        bus.tlb_req            = '0;
        bus.l2todr_req_retry   = 1'b0;
        bus.drtol2_snack_valid = 1'b0;
        bus.drtol2_snack       = '0;
        bus.l2_snack_retry     = 1'b0;
        bus.tlb_snack_retry    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic chk_all_idle(input string tag);
        chk1({tag, "_req_valid"},   bus.l2todr_req_valid,   1'b0);
        chk1({tag, "_l2_retry"},    bus.l2_req_retry,       1'b0);
        chk1({tag, "_tlb_retry"},   bus.tlb_req_retry,      1'b0);
        chk1({tag, "_snack_retry"}, bus.drtol2_snack_retry, 1'b0);
        chk1({tag, "_l2_snack_v"},  bus.l2_snack_valid,     1'b0);
        chk1({tag, "_tlb_snack_v"}, bus.tlb_snack_valid,    1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();

        //            l2v   tlbv  dret  e_l2r e_tlbr e_ov  src
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        do_reset();
        @(negedge clk);
        chk_all_idle("rst");
        cyc();

        // Request arbitration and directory back-pressure, one row per cycle
        for (int i = 0; i < 12; i++) begin
            bus.l2_req_valid     = vec[i].l2v;
            bus.l2_req           = PL;
            bus.tlb_req_valid    = vec[i].tlbv;
            bus.tlb_req          = PT;
            bus.l2todr_req_retry = vec[i].dret;
            @(negedge clk);
            chk1($sformatf("vec%0d_l2_retry", i),  bus.l2_req_retry,     vec[i].e_l2r);
            chk1($sformatf("vec%0d_tlb_retry", i), bus.tlb_req_retry,    vec[i].e_tlbr);
            chk1($sformatf("vec%0d_out_valid", i), bus.l2todr_req_valid, vec[i].e_ov);
            if (vec[i].e_ov)
                chkr($sformatf("vec%0d_out_data", i), bus.l2todr_req, (vec[i].e_src == 1) ? PL : PT);
            cyc();
        end
        drive_idle();

        // Snack steering by nodeid parity, one-cycle latency
        bus.drtol2_snack_valid = 1'b1;
        bus.drtol2_snack       = mk_snack(4);
        @(negedge clk);
        chk1("steer_retry", bus.drtol2_snack_retry, 1'b0);
        cyc();
        bus.drtol2_snack = mk_snack(5);
        @(negedge clk);
        chk1("steer4_l2_v", bus.l2_snack_valid, 1'b1);
        chks("steer4_l2_d", bus.l2_snack, mk_snack(4));
        chk1("steer4_tlb_v", bus.tlb_snack_valid, 1'b0);
        cyc();
        bus.drtol2_snack = mk_snack(6);
        @(negedge clk);
        chk1("steer5_tlb_v", bus.tlb_snack_valid, 1'b1);
        chks("steer5_tlb_d", bus.tlb_snack, mk_snack(5));
        chk1("steer5_l2_v", bus.l2_snack_valid, 1'b0);
        cyc();
        bus.drtol2_snack_valid = 1'b0;
        @(negedge clk);
        chk1("steer6_l2_v", bus.l2_snack_valid, 1'b1);
        chks("steer6_l2_d", bus.l2_snack, mk_snack(6));
        chk1("steer6_tlb_v", bus.tlb_snack_valid, 1'b0);
        cyc();

        // Blocked L2TLB sink fills its queue; L2 traffic still flows once it frees
        bus.tlb_snack_retry    = 1'b1;
        bus.drtol2_snack_valid = 1'b1;
        bus.drtol2_snack       = mk_snack(1);
        @(negedge clk);
        chk1("drain_retry0", bus.drtol2_snack_retry, 1'b0);
        cyc();
        bus.drtol2_snack = mk_snack(3);
        @(negedge clk);
        chk1("drain_retry1", bus.drtol2_snack_retry, 1'b0);
        cyc();
        bus.drtol2_snack_valid = 1'b0;
        @(negedge clk);
        chk1("drain_full_retry", bus.drtol2_snack_retry, 1'b1);
        chk1("drain_tlb_v", bus.tlb_snack_valid, 1'b1);
        chks("drain_tlb_d1", bus.tlb_snack, mk_snack(1));
        bus.tlb_snack_retry = 1'b0;
        cyc();
        bus.drtol2_snack_valid = 1'b1;
        bus.drtol2_snack       = mk_snack(8);
        @(negedge clk);
        chk1("drain_retry_clear", bus.drtol2_snack_retry, 1'b0);
        chks("drain_tlb_d3", bus.tlb_snack, mk_snack(3));
        cyc();
        bus.drtol2_snack_valid = 1'b0;
        @(negedge clk);
        chk1("drain_l2_v", bus.l2_snack_valid, 1'b1);
        chks("drain_l2_d8", bus.l2_snack, mk_snack(8));
        chk1("drain_tlb_empty", bus.tlb_snack_valid, 1'b0);
        cyc();

        // Asynchronous reset with the request queue and L2TLB snack queue both full
        do_reset();
        bus.l2_req_valid       = 1'b1;
        bus.l2_req             = PL;
        bus.tlb_req_valid      = 1'b1;
        bus.tlb_req            = PT;
        bus.l2todr_req_retry   = 1'b1;
        bus.tlb_snack_retry    = 1'b1;
        bus.drtol2_snack_valid = 1'b1;
        bus.drtol2_snack       = mk_snack(1);
        @(negedge clk);
        chk1("mid_first_l2r", bus.l2_req_retry, 1'b0);
        chk1("mid_first_tlbr", bus.tlb_req_retry, 1'b1);
        cyc();
        bus.drtol2_snack = mk_snack(3);
        @(negedge clk);
        chk1("mid_second_l2r", bus.l2_req_retry, 1'b1);
        chk1("mid_second_tlbr", bus.tlb_req_retry, 1'b0);
        cyc();
        bus.drtol2_snack_valid = 1'b0;
        @(negedge clk);
        chk1("mid_full_req_v", bus.l2todr_req_valid, 1'b1);
        chk1("mid_full_l2r", bus.l2_req_retry, 1'b1);
        chk1("mid_full_tlbr", bus.tlb_req_retry, 1'b1);
        chk1("mid_full_snack_retry", bus.drtol2_snack_retry, 1'b1);
        reset = 1'b0;
        #1;
        chk_all_idle("mid_rst");
        bus.l2todr_req_retry = 1'b0;
        bus.tlb_snack_retry  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("post_rst_l2r", bus.l2_req_retry, 1'b0);
        chk1("post_rst_tlbr", bus.tlb_req_retry, 1'b1);
        cyc();
        @(negedge clk);
        chk1("post_rst_out_v", bus.l2todr_req_valid, 1'b1);
        chkr("post_rst_out_d", bus.l2todr_req, PL);
        chk1("post_rst_tlb_snack_v", bus.tlb_snack_valid, 1'b0);
        cyc();
        drive_idle();

        // Randomized traffic against the queue model
        do_reset();
        mreq.delete();
        ms_l2.delete();
        ms_tlb.delete();
        mrr      = 1'b0;
        l2_pend  = 1'b0;
        tlb_pend = 1'b0;
        sn_pend  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!l2_pend && ($urandom % 3) != 0) begin
                l2_pend = 1'b1;
                l2_pay  = rand_req(1'b0);
            end
            if (!tlb_pend && ($urandom % 3) != 0) begin
                tlb_pend = 1'b1;
                tlb_pay  = rand_req(1'b1);
            end
            if (!sn_pend && ($urandom % 2) != 0) begin
                sn_pend = 1'b1;
                sn_pay  = rand_snack();
            end
            dret_r  = ($urandom % 4) == 0;
            l2sr_r  = ($urandom % 3) == 0;
            tlbsr_r = ($urandom % 3) == 0;
            bus.l2_req_valid       = l2_pend;
            bus.l2_req             = l2_pay;
            bus.tlb_req_valid      = tlb_pend;
            bus.tlb_req            = tlb_pay;
            bus.l2todr_req_retry   = dret_r;
            bus.drtol2_snack_valid = sn_pend;
            bus.drtol2_snack       = sn_pay;
            bus.l2_snack_retry     = l2sr_r;
            bus.tlb_snack_retry    = tlbsr_r;
            @(negedge clk);

            e_space = mreq.size() < 2;
            e_ov    = mreq.size() != 0;
            chk1("rnd_req_valid", bus.l2todr_req_valid, e_ov);
            if (e_ov) chkr("rnd_req_data", bus.l2todr_req, mreq[0]);
            chk1("rnd_l2_retry", bus.l2_req_retry, !e_space || (tlb_pend && mrr));
            chk1("rnd_tlb_retry", bus.tlb_req_retry, !e_space || (l2_pend && !mrr));
            if (e_ov && !dret_r) void'(mreq.pop_front());
            win = 0;
            if (e_space) begin
                if (l2_pend && tlb_pend) win = mrr ? 2 : 1;
                else if (l2_pend)        win = 1;
                else if (tlb_pend)       win = 2;
            end
            if (win == 1) begin
                mreq.push_back(l2_pay);
                l2_pend = 1'b0;
                mrr     = 1'b1;
            end else if (win == 2) begin
                mreq.push_back(tlb_pay);
                tlb_pend = 1'b0;
                mrr      = 1'b0;
            end

            e_sfull = (ms_l2.size() == 2) || (ms_tlb.size() == 2);
            chk1("rnd_snack_retry", bus.drtol2_snack_retry, e_sfull);
            chk1("rnd_l2_snack_v", bus.l2_snack_valid, ms_l2.size() != 0);
            if (ms_l2.size() != 0) chks("rnd_l2_snack_d", bus.l2_snack, ms_l2[0]);
            chk1("rnd_tlb_snack_v", bus.tlb_snack_valid, ms_tlb.size() != 0);
            if (ms_tlb.size() != 0) chks("rnd_tlb_snack_d", bus.tlb_snack, ms_tlb[0]);
            if (ms_l2.size() != 0 && !l2sr_r)   void'(ms_l2.pop_front());
            if (ms_tlb.size() != 0 && !tlbsr_r) void'(ms_tlb.pop_front());
            if (sn_pend && !e_sfull) begin
                if (sn_pay[SNACK_NID_BIT]) ms_tlb.push_back(sn_pay);
                else                       ms_l2.push_back(sn_pay);
                sn_pend = 1'b0;
            end
            cyc();
        end
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
